// File: rtl/romload_pkg.sv
// ----------------------------------------------------------------------------
// romload_pkg : shared types and constants for the ROM-load sink
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package romload_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int ADDR_W     = 24;
  localparam int DATA_W     = 16;
  localparam int DS_W       = 2;
  localparam int ENTRY_W    = ADDR_W + DATA_W + DS_W;
  localparam int WR_GAP_DEF = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DS_W-1:0]   ds;
  } entry_t;

endpackage

`default_nettype wire

// File: rtl/romload_fifo.sv
// ----------------------------------------------------------------------------
// romload_fifo : generic synchronous FIFO with registered read data
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module romload_fifo #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 8
) (
  input  logic                       wclk,
  input  logic                       resetn,
  input  logic                       i_clr,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   C_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] C_PINC  = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;
  logic [WIDTH-1:0] r_rdata;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_cnt == C_DEPTH);
  assign o_empty   = (r_cnt == '0);
  assign o_count   = r_cnt;
  assign o_rdata   = r_rdata;
  // A full FIFO still accepts a push when the same cycle frees a slot
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge wclk) begin
    if (w_do_push) r_mem[r_wp] <= i_wdata;
  end

  always_ff @(posedge wclk) begin
    if (!resetn || i_clr) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + C_PINC;
      if (w_do_pop) begin
        r_rdata <= r_mem[r_rp];
        r_rp    <= r_rp + C_PINC;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + C_ONE;
        2'b01:   r_cnt <= r_cnt - C_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/romload_sink.sv
// ----------------------------------------------------------------------------
// romload_sink : packs the iosys ROM byte stream into words and writes SDRAM
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module romload_sink
  import romload_pkg::*;
#(
  parameter logic [22:0] ROM_BASE   = 23'h000000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          WR_GAP     = WR_GAP_DEF
) (
  input  logic        wclk,
  input  logic        resetn,
  input  logic        rom_loading,
  input  logic [7:0]  rom_do,
  input  logic        rom_do_valid,
  input  logic [23:0] rom_mask,
  output logic [22:0] ram_addr,
  output logic [15:0] ram_din,
  output logic [1:0]  ram_ds,
  output logic        ram_wr,
  input  logic        ram_busy,
  output logic        load_done,
  output logic [23:0] byte_cnt,
  output logic        overflow
);

  state_t      r_state;
  logic        r_loading_q;
  logic [23:0] r_byte_cnt;
  logic [7:0]  r_low;
  logic        r_flush_first;
  logic        r_overflow;
  logic        r_load_done;
  logic        r_wr;
  logic [7:0]  r_gap;

  logic        w_rise;
  logic        w_fall;
  logic        w_byte;
  logic        w_pack_push;
  logic        w_tail_push;
  logic        w_push_req;
  logic        w_push;
  logic        w_drop;
  logic        w_fire;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] w_fifo_count;
  entry_t      w_wentry;
  logic [ENTRY_W-1:0] w_rdata;
  entry_t      w_head;
  logic [23:0] w_sum;
  logic        w_unused;

  assign w_rise = rom_loading && !r_loading_q;
  assign w_fall = !rom_loading && r_loading_q;

  assign w_byte      = (r_state == ST_LOAD) && rom_do_valid && !w_rise;
  assign w_pack_push = w_byte && r_byte_cnt[0];
  // A dangling odd byte is committed once, on the first FLUSH cycle
  assign w_tail_push = (r_state == ST_FLUSH) && r_flush_first && r_byte_cnt[0] && !w_rise;
  assign w_push_req  = w_pack_push || w_tail_push;
  assign w_drop      = w_push_req && w_fifo_full && !w_fire;
  assign w_push      = w_push_req && !w_drop;

  always_comb begin
    w_wentry.addr = {r_byte_cnt[23:1], 1'b0};
    if (w_tail_push) begin
      w_wentry.data = {8'h00, r_low};
      w_wentry.ds   = 2'b01;
    end else begin
      w_wentry.data = {rom_do, r_low};
      w_wentry.ds   = 2'b11;
    end
  end

  assign w_fire = !w_fifo_empty && !ram_busy && (r_gap == 8'd0) && !r_wr && !w_rise;

  romload_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .wclk    (wclk),
    .resetn  (resetn),
    .i_clr   (w_rise),
    .i_push  (w_push),
    .i_wdata (w_wentry),
    .i_pop   (w_fire),
    .o_rdata (w_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign w_head   = entry_t'(w_rdata);
  assign w_sum    = {1'b0, ROM_BASE} + (w_head.addr & rom_mask);
  assign w_unused = &{1'b0, w_sum[23], w_sum[0], w_fifo_count};

  // Write-port fields follow the popped entry only while the strobe is up
  assign ram_wr    = r_wr;
  assign ram_addr  = r_wr ? {w_sum[22:1], 1'b0} : 23'd0;
  assign ram_din   = r_wr ? w_head.data : 16'd0;
  assign ram_ds    = r_wr ? w_head.ds : 2'd0;
  assign load_done = r_load_done;
  assign byte_cnt  = r_byte_cnt;
  assign overflow  = r_overflow;

  always_ff @(posedge wclk) begin
    if (!resetn) begin
      r_wr  <= 1'b0;
      r_gap <= 8'd0;
    end else begin
      r_wr <= w_fire;
      if (r_wr)
        r_gap <= 8'(WR_GAP);
      else if (r_gap != 8'd0)
        r_gap <= r_gap - 8'd1;
    end
  end

  always_ff @(posedge wclk) begin
    if (!resetn) begin
      r_state       <= ST_IDLE;
      r_loading_q   <= 1'b0;
      r_byte_cnt    <= 24'd0;
      r_low         <= 8'd0;
      r_flush_first <= 1'b0;
      r_overflow    <= 1'b0;
      r_load_done   <= 1'b0;
    end else begin
      r_loading_q <= rom_loading;
      r_load_done <= 1'b0;
      if (w_drop) r_overflow <= 1'b1;
      if (w_rise) begin
        r_state       <= ST_LOAD;
        r_byte_cnt    <= 24'd0;
        r_low         <= 8'd0;
        r_flush_first <= 1'b0;
        r_overflow    <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_IDLE;
          ST_LOAD: begin
            if (w_byte) begin
              r_byte_cnt <= r_byte_cnt + 24'd1;
              if (!r_byte_cnt[0]) r_low <= rom_do;
            end
            if (w_fall) begin
              r_state       <= ST_FLUSH;
              r_flush_first <= 1'b1;
            end
          end
          ST_FLUSH: begin
            r_flush_first <= 1'b0;
            if (!r_flush_first && w_fifo_empty && !r_wr) r_state <= ST_DONE;
          end
          ST_DONE: begin
            r_load_done <= 1'b1;
            r_state     <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_romload_sink.sv
// ----------------------------------------------------------------------------
// tb_romload_sink : randomized scoreboard bench for romload_sink
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_romload_sink;

  localparam logic [22:0] ROM_BASE   = 23'h000000;
  localparam int          FIFO_DEPTH = 8;
  localparam int          WR_GAP     = 2;
  localparam int          UNLIMITED  = 1 << 30;

  logic        wclk = 1'b0;
  logic        resetn;
  logic        rom_loading;
  logic [7:0]  rom_do;
  logic        rom_do_valid;
  logic [23:0] rom_mask;
  logic [22:0] ram_addr;
  logic [15:0] ram_din;
  logic [1:0]  ram_ds;
  logic        ram_wr;
  logic        ram_busy;
  logic        load_done;
  logic [23:0] byte_cnt;
  logic        overflow;

  romload_sink #(
    .ROM_BASE   (ROM_BASE),
    .FIFO_DEPTH (FIFO_DEPTH),
    .WR_GAP     (WR_GAP)
  ) dut (
    .wclk         (wclk),
    .resetn       (resetn),
    .rom_loading  (rom_loading),
    .rom_do       (rom_do),
    .rom_do_valid (rom_do_valid),
    .rom_mask     (rom_mask),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_ds       (ram_ds),
    .ram_wr       (ram_wr),
    .ram_busy     (ram_busy),
    .load_done    (load_done),
    .byte_cnt     (byte_cnt),
    .overflow     (overflow)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic [22:0] addr;
    logic [15:0] din;
    logic [1:0]  ds;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  wr_cnt = 0;
  int  done_cnt = 0;
  int  first_wr_cyc = -1;
  int  last_cyc = 0;
  logic prev_busy = 1'b0;
  bit  rand_busy = 1'b0;

  // Reference model state: byte stream view of one load
  int          m_cnt;
  logic [7:0]  m_low;
  int          m_room;
  logic        m_ovf;
  logic [23:0] m_mask;

  always @(posedge wclk) cyc <= cyc + 1;

  function automatic void chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [22:0] exp_addr(input int unsigned idx);
    logic [31:0] s;
    s = 32'(ROM_BASE) + 32'((24'(idx) & ~24'd1) & m_mask);
    s[0] = 1'b0;
    return s[22:0];
  endfunction

  function automatic void model_word(input int idx, input logic [15:0] din, input logic [1:0] ds);
    wr_t e;
    if (m_room == 0) begin
      m_ovf = 1'b1;
    end else begin
      m_room--;
      e.addr = exp_addr(idx);
      e.din  = din;
      e.ds   = ds;
      exp_q.push_back(e);
    end
  endfunction

  // Monitor: pops the scoreboard on every write strobe
  always @(negedge wclk) begin
    wr_t e;
    if (ram_wr === 1'b1) begin
      wr_cnt++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      chk("wr_while_busy", prev_busy, 0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0h din %0h ds %0h, expected none", ram_addr, ram_din, ram_ds);
      end else begin
        e = exp_q.pop_front();
        chk("ram_addr", ram_addr, e.addr);
        chk("ram_din", ram_din, e.din);
        chk("ram_ds", ram_ds, e.ds);
      end
    end
    if (load_done === 1'b1) begin
      done_cnt++;
      chk("writes_before_done", exp_q.size(), 0);
    end
    prev_busy = ram_busy;
  end

  task automatic tick();
    @(posedge wclk);
    #1;
    if (rand_busy) ram_busy = ($urandom_range(0, 7) == 0);
  endtask

  task automatic start_load(input logic [23:0] mask, input int room);
    rom_mask    = mask;
    m_mask      = mask;
    m_cnt       = 0;
    m_room      = room;
    m_ovf       = 1'b0;
    rom_loading = 1'b1;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rom_do       = b;
    rom_do_valid = 1'b1;
    last_cyc     = cyc;
    tick();
    rom_do_valid = 1'b0;
    if (m_cnt % 2 == 1) model_word(m_cnt - 1, {b, m_low}, 2'b11);
    else m_low = b;
    m_cnt++;
    repeat (gap) tick();
  endtask

  task automatic end_load();
    rom_loading = 1'b0;
    if (m_cnt % 2 == 1) model_word(m_cnt - 1, {8'h00, m_low}, 2'b01);
    tick();
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    chk("load_done_seen", done_cnt - d0, 1);
    repeat (4) tick();
    chk("load_done_once", done_cnt - d0, 1);
    chk("byte_cnt", byte_cnt, 24'(m_cnt));
    chk("overflow", overflow, m_ovf);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic chk_reset();
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    chk("rst_ram_ds", ram_ds, 0);
    chk("rst_ram_wr", ram_wr, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_byte_cnt", byte_cnt, 0);
    chk("rst_overflow", overflow, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] masks [3];
    int w0;
    int b2;
    int len;
    masks[0] = 24'hFFFFFF;
    masks[1] = 24'h0000FF;
    masks[2] = 24'h001FFF;

    resetn       = 1'b0;
    rom_loading  = 1'b0;
    rom_do       = 8'h00;
    rom_do_valid = 1'b0;
    rom_mask     = 24'hFFFFFF;
    ram_busy     = 1'b0;
    repeat (3) tick();
    chk_reset();
    resetn = 1'b1;
    tick();

    // Single burst on consecutive cycles, plus write latency
    first_wr_cyc = -1;
    start_load(24'hFFFFFF, UNLIMITED);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    b2 = last_cyc;
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    end_load();
    wait_done(200);
    chk("wr_latency", first_wr_cyc - b2, 2);

    // Odd tail
    start_load(24'hFFFFFF, UNLIMITED);
    send_byte(8'hAA, 1);
    send_byte(8'hBB, 1);
    send_byte(8'hCC, 1);
    end_load();
    wait_done(200);

    // Zero-byte load
    w0 = wr_cnt;
    start_load(24'hFFFFFF, UNLIMITED);
    end_load();
    wait_done(200);
    chk("zero_load_writes", wr_cnt - w0, 0);

    // Mask wrap over 2048 bytes
    start_load(24'h0003FF, UNLIMITED);
    for (int i = 0; i < 2048; i++) send_byte(8'($urandom), 2);
    end_load();
    wait_done(200);

    // Random loads with occasional busy
    for (int k = 0; k < 4; k++) begin
      len = $urandom_range(0, 41);
      start_load(masks[$urandom_range(0, 2)], UNLIMITED);
      rand_busy = 1'b1;
      for (int i = 0; i < len; i++) send_byte(8'($urandom), $urandom_range(3, 5));
      rand_busy = 1'b0;
      ram_busy  = 1'b0;
      end_load();
      wait_done(300);
    end

    // Backpressure: 16 bytes absorbed while busy
    ram_busy = 1'b1;
    w0 = wr_cnt;
    start_load(24'hFFFFFF, FIFO_DEPTH);
    for (int i = 0; i < 16; i++) send_byte(8'(8'h40 + i), 0);
    repeat (23) tick();
    chk("bp_no_wr_while_busy", wr_cnt - w0, 0);
    ram_busy = 1'b0;
    m_room   = UNLIMITED;
    end_load();
    wait_done(200);
    chk("bp_total_writes", wr_cnt - w0, 8);

    // Overflow: 20 bytes while busy
    ram_busy = 1'b1;
    w0 = wr_cnt;
    start_load(24'hFFFFFF, FIFO_DEPTH);
    for (int i = 0; i < 17; i++) send_byte(8'(8'h80 + i), 0);
    chk("ovf_before_18", overflow, 0);
    send_byte(8'h91, 0);
    chk("ovf_after_18", overflow, 1);
    send_byte(8'h92, 0);
    send_byte(8'h93, 0);
    repeat (5) tick();
    ram_busy = 1'b0;
    m_room   = UNLIMITED;
    end_load();
    wait_done(200);
    chk("ovf_total_writes", wr_cnt - w0, 8);

    // Reset in the middle of a load
    ram_busy = 1'b1;
    start_load(24'hFFFFFF, FIFO_DEPTH);
    for (int i = 0; i < 6; i++) send_byte(8'(8'hC0 + i), 0);
    resetn      = 1'b0;
    rom_loading = 1'b0;
    tick();
    tick();
    chk_reset();
    exp_q.delete();
    w0 = wr_cnt;
    resetn   = 1'b1;
    ram_busy = 1'b0;
    repeat (20) tick();
    chk("no_wr_after_reset", wr_cnt - w0, 0);
    start_load(24'hFFFFFF, UNLIMITED);
    send_byte(8'h5A, 0);
    send_byte(8'hA5, 0);
    send_byte(8'h3C, 0);
    send_byte(8'hC3, 0);
    end_load();
    wait_done(200);
    chk("post_reset_writes", wr_cnt - w0, 2);

    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
